// File: rtl/elevator_call_panel.sv
// elevator_call_panel
//
// Front end of the elevator: synchronizes and debounces the three car buttons
// and the three hall buttons, latches each accepted press as a lit lamp plus a
// pending request, and serializes pending requests onto the interior/exterior
// panel buses as one-hot single-cycle pulses. Every pulse is followed by at
// least one all-zero cycle, so the movement controller always gets idle time.
//
// Sources s0..s2 are car buttons for floors 1..3, s3..s5 are hall buttons for
// floors 1..3. Pending requests are granted round-robin from a pointer that
// starts at s0 and moves to the slot after each issued request.
//
// Ports:
//   CLK             in   rising-edge clock
//   RST             in   asynchronous active-high reset
//   logged_in       in   issue enable; car presses are accepted only while high
//   btn_int[2:0]    in   raw car buttons (asynchronous), bit0 = floor 1
//   btn_ext[2:0]    in   raw hall buttons (asynchronous), bit0 = floor 1
//   doors[2:0]      in   door-open status per floor; clears that floor's lamps
//   interior_panel  out  one-hot request pulse, car source (registered)
//   exterior_panel  out  one-hot request pulse, hall source (registered)
//   lamp_int        out  car button lamps (registered)
//   lamp_ext        out  hall button lamps (registered)
//
// Build option:
//   CALL_PANEL_REISSUE_EN  when defined, a per-source timer re-raises the
//                          pending request every REISSUE_PERIOD cycles while
//                          the lamp stays lit, recovering dropped requests.
//                          When undefined, each accepted press issues once.

module elevator_call_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REISSUE_PERIOD  = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       logged_in,
    input  logic [2:0] btn_int,
    input  logic [2:0] btn_ext,
    input  logic [2:0] doors,
    output logic [2:0] interior_panel,
    output logic [2:0] exterior_panel,
    output logic [2:0] lamp_int,
    output logic [2:0] lamp_ext
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [5:0] raw_btn;
    logic [5:0] sync1_d, sync1_q;
    logic [5:0] sync2_d, sync2_q;
    logic [5:0] deb_d, deb_q;
    logic [5:0] lamp_d, lamp_q;
    logic [5:0] pending_d, pending_q;
    logic [5:0] press;
    logic [5:0] accept;
    logic [5:0] floor_clear;
    logic [5:0] issue_clear;
    logic [5:0] reissue_set;
    logic [5:0] grant_onehot;

    state_t     state_d, state_q;
    logic [2:0] grant_d, grant_q;
    logic [2:0] ptr_d, ptr_q;
    logic [2:0] interior_panel_d, interior_panel_q;
    logic [2:0] exterior_panel_d, exterior_panel_q;

    logic       rr_found;
    logic [2:0] rr_idx;
    logic       grant_ok;

    assign raw_btn     = {btn_ext, btn_int};
    assign floor_clear = {doors, doors};

    // Two-flop synchronizer for every raw button.
    always_comb begin
        sync1_d = raw_btn;
        sync2_d = sync1_q;
    end

    // Per-source debounce. The counter runs only while the synchronized level
    // disagrees with the debounced one; the toggle happens on the cycle after
    // the count has reached the limit, giving 2 + DEBOUNCE_CYCLES press latency.
    for (genvar s = 0; s < 6; s++) begin : g_deb
        logic [7:0] cnt_d, cnt_q;
        logic       toggle;

        always_comb begin
            cnt_d  = 8'd0;
            toggle = 1'b0;
            if (sync2_q[s] != deb_q[s]) begin
                if (cnt_q == DEB_LIMIT) begin
                    toggle = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                cnt_q <= 8'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign deb_d[s] = deb_q[s] ^ toggle;
        assign press[s] = toggle & ~deb_q[s];
    end

    // Car presses additionally require logged_in; a rejected press is dropped.
    assign accept = press & ~lamp_q & ~floor_clear & {3'b111, {3{logged_in}}};

`ifdef CALL_PANEL_REISSUE_EN
    localparam int RW = $clog2(REISSUE_PERIOD + 1);

    // Reissue timer runs only while the lamp is lit and nothing is pending;
    // it restarts whenever a request is re-raised or the lamp goes dark.
    for (genvar s = 0; s < 6; s++) begin : g_reissue
        logic [RW-1:0] timer_d, timer_q;
        logic          fire;

        always_comb begin
            timer_d = '0;
            fire    = 1'b0;
            if (lamp_q[s] && !pending_q[s] && !floor_clear[s]) begin
                if (timer_q == RW'(REISSUE_PERIOD - 1)) begin
                    fire = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_d;
            end
        end

        assign reissue_set[s] = fire;
    end
`else
    assign reissue_set = 6'b000000;
`endif

    // Round-robin search starting at the pointer, wrapping after s5.
    always_comb begin
        logic [3:0] sum;
        logic [2:0] cand;
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        sum      = 4'd0;
        cand     = 3'd0;
        for (int k = 0; k < 6; k++) begin
            sum  = {1'b0, ptr_q} + 4'(k);
            cand = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
            if (!rr_found && pending_q[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign grant_ok     = logged_in && rr_found;
    assign grant_onehot = 6'b000001 << grant_q;

    // Issue FSM next-state. The panel pulse is registered from the ISSUE state,
    // so it appears one cycle after ISSUE is entered and always lands while the
    // FSM sits in GAP or later; an in-flight grant completes regardless of
    // doors or logged_in.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        ptr_d            = ptr_q;
        issue_clear      = 6'b000000;
        interior_panel_d = 3'b000;
        exterior_panel_d = 3'b000;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    grant_d = rr_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                interior_panel_d = grant_onehot[2:0];
                exterior_panel_d = grant_onehot[5:3];
                issue_clear      = grant_onehot;
                ptr_d            = (grant_q == 3'd5) ? 3'd0 : grant_q + 3'd1;
                state_d          = GAP;
            end
            GAP: begin
                if (grant_ok) begin
                    grant_d = rr_idx;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Door-open clear wins over a same-cycle press or reissue.
    always_comb begin
        lamp_d    = (lamp_q | accept) & ~floor_clear;
        pending_d = ((pending_q & ~issue_clear) | accept | reissue_set) & ~floor_clear;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q          <= 6'b000000;
            sync2_q          <= 6'b000000;
            deb_q            <= 6'b000000;
            lamp_q           <= 6'b000000;
            pending_q        <= 6'b000000;
            state_q          <= IDLE;
            grant_q          <= 3'd0;
            ptr_q            <= 3'd0;
            interior_panel_q <= 3'b000;
            exterior_panel_q <= 3'b000;
        end else begin
            sync1_q          <= sync1_d;
            sync2_q          <= sync2_d;
            deb_q            <= deb_d;
            lamp_q           <= lamp_d;
            pending_q        <= pending_d;
            state_q          <= state_d;
            grant_q          <= grant_d;
            ptr_q            <= ptr_d;
            interior_panel_q <= interior_panel_d;
            exterior_panel_q <= exterior_panel_d;
        end
    end

    assign interior_panel = interior_panel_q;
    assign exterior_panel = exterior_panel_q;
    assign lamp_int       = lamp_q[2:0];
    assign lamp_ext       = lamp_q[5:3];

endmodule

// File: doc/elevator_call_panel.md
# elevator_call_panel

Front end of the elevator that turns raw car and hall push-buttons into the request pulses consumed by the movement controller. It synchronizes and debounces six buttons, latches each accepted press as a lit lamp plus a pending request, and serializes pending requests onto the `interior_panel` / `exterior_panel` buses as one-hot single-cycle pulses separated by all-zero gaps, so the movement FSM always gets idle cycles to act. Lamps clear when the movement controller reports the door open at that floor.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized level must differ from the debounced level before it is accepted (1..255).
- `REISSUE_PERIOD`, default 64: cycles between automatic reissues. Used only with `CALL_PANEL_REISSUE_EN`.

Ports:
- `CLK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `logged_in`  in  1  issue enable; interior presses are accepted only while high.
- `btn_int`  in  3  raw car buttons, asynchronous; bit0 = floor 1, bit2 = floor 3.
- `btn_ext`  in  3  raw hall buttons, asynchronous; same bit order.
- `doors`  in  3  door-open status from the movement controller, one-hot per floor.
- `interior_panel`  out  3  one-hot request pulse, car source.
- `exterior_panel`  out  3  one-hot request pulse, hall source.
- `lamp_int`  out  3  car button lamps.
- `lamp_ext`  out  3  hall button lamps.

## Operation
- **Input path, per button (6 total):**
  - 2-flop synchronizer.
  - 8-bit debounce counter. It counts while the synchronized level differs from the debounced level and resets to 0 when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
- **Press acceptance:** a press is the rising edge of the debounced level. It is accepted only if all of these hold:
  - the lamp for that button is not already lit;
  - `doors[i]` is 0 in the same cycle;
  - for interior buttons, `logged_in` is 1.
- **On acceptance:** set `lamp[s]` and `pending[s]`. Sources s0..s5 are int F1..F3, then ext F1..F3. A rejected press is discarded entirely.
- **Lamp clear:**
  - `doors[i]` = 1 clears `lamp_int[i]`, `lamp_ext[i]`, and both pending bits for floor i in that cycle.
  - A clear takes priority over a same-cycle set.
- **Issue FSM:** states IDLE, ISSUE, GAP.
  - IDLE: if `logged_in` and any pending bit is set, grant by round-robin, then go to ISSUE.
  - ISSUE: drive exactly one bit of the granted source's panel bus. Clear its pending bit. Set the pointer to (grant+1) mod 6. Go to GAP.
  - GAP: both buses are 0. If `logged_in` and any pending bit is set, grant and go to ISSUE; otherwise go to IDLE.
- **Round-robin:** the pointer resets to s0. The search runs pointer, pointer+1, … with wrap.
- **Hold-off:** while `logged_in` = 0, no grants are made; pending bits are retained.
- **Issue already in flight:**
  - If `doors` clears the granted pending bit while in ISSUE, the registered pulse still completes.
  - If `logged_in` falls during ISSUE, the pulse still completes.
- **Reset:** any time, including mid-pulse, returns all state to reset values immediately.

## Timing
- **Reset values:**
  - `interior_panel` = 0, `exterior_panel` = 0, `lamp_int` = 0, `lamp_ext` = 0.
  - pending = 0, debounced levels = 0, counters = 0, FSM = IDLE, pointer = s0.
  - Synchronizer flops = 0.
- **All outputs are registered.**
- **Latency, raw press to lamp:** 2 + `DEBOUNCE_CYCLES` cycles. With the default this is 6 cycles after the sampling edge that first sees the button high.
- **Latency, lamp to panel pulse:** 2 cycles from IDLE (grant, then ISSUE). The pulse is exactly 1 cycle wide.
- **Throughput:** at most one request every 2 cycles. A GAP cycle always follows every ISSUE cycle.
- **Never:** both buses nonzero at once, or any bus with more than one bit set.
- **Release:** needs `DEBOUNCE_CYCLES` stable-low cycles after synchronization before the next press can be recognized.

## Configuration
- `CALL_PANEL_REISSUE_EN` defined:
  - A per-source reissue timer runs while the lamp is lit and pending is clear.
  - After `REISSUE_PERIOD` cycles, pending is set again and the timer restarts.
  - This recovers requests the movement controller dropped.
  - The timer clears with the lamp.
- Not defined: each accepted press is issued exactly once, and the timers are not instantiated.

## Test plan
- **Single press:** `logged_in` = 1; hold `btn_int[2]` for 10 cycles.
  - `lamp_int` = 3'b100 six cycles later.
  - `interior_panel` = 3'b100 for exactly 1 cycle, 2 cycles after that.
  - No further pulses.
- **Bounce:** toggle `btn_ext[0]` every 2 cycles for 12 cycles, then hold low → no lamp, no pulse.
- **Simultaneous presses:** `btn_int[0]`, `btn_ext[1]`, and `btn_ext[2]` all rise together.
  - Pulses appear in order int 3'b001, ext 3'b010, ext 3'b100.
  - Each is 1 cycle with a 1-cycle zero gap between.
- **Arrival:**
  - With `lamp_ext[1]` lit, drive `doors` = 3'b010 → lamp clears the next edge.
  - A hall F2 press while `doors` = 3'b010 is ignored.
- **Login gating:**
  - `logged_in` = 0: an interior press yields no lamp; an exterior press lights its lamp but issues no pulse.
  - Raise `logged_in` → the exterior pulse issues 2 cycles later.
- **Reset mid-pulse:** assert `RST` during ISSUE → all outputs 0 immediately. After release there are no pulses until a new press.
